apb_requester: RTL and testbench

APB_REQUESTER -- requirements
Module: apb_requester

---
 rtl/apb_requester_if.sv | 42 ++++
 rtl/apb_requester.sv | 143 ++++++++++++++
 tb/tb_apb_requester.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_requester_if.sv
// Bundles the command/response handshake and the APB completer bus of apb_requester.
// The master modport is the requester's view; the slave modport is the environment's view.
interface apb_requester_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_requester.sv
// Single-outstanding APB requester: turns one command into an IDLE/SETUP/ACCESS transfer
// and returns a one-cycle response, aborting with a timeout if PREADY never arrives.
module apb_requester #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic            clk,
    input logic            rst,
    apb_requester_if.master bus
);

    // Counter is wide enough to hold TIMEOUT_CYCLES; with the timeout disabled it just saturates.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_r;
    logic                  req_ready_r;
    logic                  psel_r;
    logic                  penable_r;
    logic                  pwrite_r;
    logic [ADDR_WIDTH-1:0] paddr_r;
    logic [DATA_WIDTH-1:0] pwdata_r;
    logic                  rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;
    logic                  rsp_err_r;
    logic                  rsp_timeout_r;
    logic [CNT_W-1:0]      wait_cnt_r;

    logic                  handshake_s;
    logic                  timeout_hit_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    assign handshake_s = bus.req_valid & req_ready_r;

    // The current ACCESS cycle is the last one allowed before the transfer is abandoned.
    always_comb begin
        timeout_hit_s = 1'b0;
        if (TIMEOUT_EN && (wait_cnt_r == CNT_LAST)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Transfer sequencer with all bus and response outputs held in registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            req_ready_r   <= 1'b0;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= '0;
            pwdata_r      <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
            wait_cnt_r    <= '0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (handshake_s) begin
                        pwrite_r    <= bus.req_write;
                        paddr_r     <= bus.req_addr;
                        pwdata_r    <= bus.req_wdata;
                        psel_r      <= 1'b1;
                        penable_r   <= 1'b0;
                        req_ready_r <= 1'b0;
                        wait_cnt_r  <= '0;
                        state_r     <= SETUP;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                SETUP: begin
                    penable_r <= 1'b1;
                    state_r   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY takes priority over a timeout landing on the same edge.
                    if (bus.PREADY) begin
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= pwrite_r ? '0 : bus.PRDATA;
                        rsp_err_r     <= bus.PSLVERR;
                        rsp_timeout_r <= 1'b0;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        req_ready_r   <= 1'b1;
                        state_r       <= IDLE;
                    end else if (timeout_hit_s) begin
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= '0;
                        rsp_err_r     <= 1'b1;
                        rsp_timeout_r <= 1'b1;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        req_ready_r   <= 1'b1;
                        state_r       <= IDLE;
                    end else begin
                        wait_cnt_r <= sat_inc(wait_cnt_r);
                    end
                end
                default: begin
                    psel_r      <= 1'b0;
                    penable_r   <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rsp_rdata_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.rsp_timeout = rsp_timeout_r;
    assign bus.PSEL        = psel_r;
    assign bus.PENABLE     = penable_r;
    assign bus.PWRITE      = pwrite_r;
    assign bus.PADDR       = paddr_r;
    assign bus.PWDATA      = pwdata_r;

endmodule

// File: tb/tb_apb_requester.sv
// Scoreboard bench for apb_requester: a scripted completer answers each transfer per plan,
// and a monitor checks every response against a transaction-level reference model.
module tb_apb_requester;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apb_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            w;      // ACCESS cycles with PREADY low before PREADY rises
        logic [DW-1:0] d;
        logic          e;
    } plan_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
        int            edge_n;
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Number of ACCESS cycles the transfer occupies on the bus.
    function automatic int n_access(input int w);
        if (T > 0 && w >= T) return T;
        return w + 1;
    endfunction

    function automatic exp_t model(input plan_t p, input int hs_edge);
        exp_t r;
        r.tmo    = (T > 0 && p.w >= T);
        r.err    = r.tmo ? 1'b1 : p.e;
        r.rdata  = (r.tmo || p.wr) ? '0 : p.d;
        r.edge_n = hs_edge + 1 + n_access(p.w);
        return r;
    endfunction

    task automatic issue(input plan_t p, output int hs_edge);
        int   n;
        logic hs;
        bus_if.req_valid = 1'b1;
        bus_if.req_write = p.wr;
        bus_if.req_addr  = p.addr;
        bus_if.req_wdata = p.wdata;
        n       = 0;
        hs_edge = -1;
        while (hs_edge < 0) begin
            hs = bus_if.req_ready;
            if (hs) begin
                hs_edge = cyc + 1;
                plan_q.push_back(p);
                exp_q.push_back(model(p, cyc + 1));
            end
            @(posedge clk); #1;
            if (!hs) begin
                n++;
                if (n > 300) begin
                    chk("handshake_wait", 64'd0, 64'd1);
                    break;
                end
            end
        end
        bus_if.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus_if.PSEL) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_wait", 64'(n < 200), 64'd1);
    endtask

    function automatic plan_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                 input int w, input logic [DW-1:0] d, input logic e);
        plan_t p;
        p.wr = wr; p.addr = a; p.wdata = wd; p.w = w; p.d = d; p.e = e;
        return p;
    endfunction

    // Completer: answers transfers according to the popped plan, drives junk elsewhere.
    plan_t cur;
    int    k = 0;
    bit    in_xfer = 1'b0;
    bit    prev_setup = 1'b0;
    initial begin
        bus_if.PREADY  = 1'b0;
        bus_if.PSLVERR = 1'b0;
        bus_if.PRDATA  = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                in_xfer    = 1'b0;
                prev_setup = 1'b0;
                bus_if.PREADY  = 1'($urandom_range(0, 1));
                bus_if.PSLVERR = 1'($urandom_range(0, 1));
                bus_if.PRDATA  = $urandom;
            end else if (bus_if.PSEL && !bus_if.PENABLE) begin
                chk("setup_one_cycle", 64'(prev_setup), 64'd0);
                prev_setup = 1'b1;
                if (plan_q.size() == 0) begin
                    chk("setup_without_cmd", 64'd1, 64'd0);
                    in_xfer = 1'b0;
                end else begin
                    cur = plan_q.pop_front();
                    chk("setup_paddr", 64'(bus_if.PADDR), 64'(cur.addr));
                    chk("setup_pwrite", 64'(bus_if.PWRITE), 64'(cur.wr));
                    chk("setup_pwdata", 64'(bus_if.PWDATA), 64'(cur.wdata));
                    in_xfer = 1'b1;
                    k = 0;
                end
                bus_if.PREADY  = 1'($urandom_range(0, 1));
                bus_if.PSLVERR = 1'($urandom_range(0, 1));
                bus_if.PRDATA  = $urandom;
            end else if (bus_if.PSEL && bus_if.PENABLE) begin
                prev_setup = 1'b0;
                chk("access_in_transfer", 64'(in_xfer), 64'd1);
                chk("access_paddr", 64'(bus_if.PADDR), 64'(cur.addr));
                chk("access_pwrite", 64'(bus_if.PWRITE), 64'(cur.wr));
                chk("access_pwdata", 64'(bus_if.PWDATA), 64'(cur.wdata));
                if (k >= cur.w) begin
                    bus_if.PREADY  = 1'b1;
                    bus_if.PRDATA  = cur.d;
                    bus_if.PSLVERR = cur.e;
                end else begin
                    bus_if.PREADY  = 1'b0;
                    bus_if.PRDATA  = $urandom;
                    bus_if.PSLVERR = 1'($urandom_range(0, 1));
                end
                k++;
            end else begin
                if (in_xfer) chk("access_cycles", 64'(k), 64'(n_access(cur.w)));
                in_xfer    = 1'b0;
                prev_setup = 1'b0;
                bus_if.PREADY  = 1'($urandom_range(0, 1));
                bus_if.PSLVERR = 1'($urandom_range(0, 1));
                bus_if.PRDATA  = $urandom;
            end
        end
    end

    // Monitor: every response pulse is matched against the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (bus_if.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", 64'(bus_if.rsp_rdata), 64'(e.rdata));
                    chk("rsp_err", 64'(bus_if.rsp_err), 64'(e.err));
                    chk("rsp_timeout", 64'(bus_if.rsp_timeout), 64'(e.tmo));
                    chk("rsp_latency", 64'(cyc), 64'(e.edge_n));
                    chk("psel_at_rsp", 64'({bus_if.PSEL, bus_if.PENABLE}), 64'd0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int    hs1, hs2, n;
        plan_t p;
        rst = 1'b1;
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(bus_if.req_ready), 64'd0);
        chk("rst_psel", 64'(bus_if.PSEL), 64'd0);
        chk("rst_penable", 64'(bus_if.PENABLE), 64'd0);
        chk("rst_pwrite", 64'(bus_if.PWRITE), 64'd0);
        chk("rst_paddr", 64'(bus_if.PADDR), 64'd0);
        chk("rst_pwdata", 64'(bus_if.PWDATA), 64'd0);
        chk("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(bus_if.rsp_err), 64'd0);
        chk("rst_rsp_timeout", 64'(bus_if.rsp_timeout), 64'd0);
        chk("rst_rsp_rdata", 64'(bus_if.rsp_rdata), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_release", 64'(bus_if.req_ready), 64'd1);

        // Directed scenarios: plain write, waited read, slave error, timeout and its boundary.
        issue(mk(1'b1, 32'h8000_1000, 32'h0000_00AA, 0, 32'h1234_5678, 1'b0), hs1); wait_idle();
        issue(mk(1'b0, 32'h8000_1018, 32'h0BAD_0BAD, 3, 32'h0000_0011, 1'b0), hs1); wait_idle();
        issue(mk(1'b1, 32'h8000_1014, 32'h0000_0001, 0, 32'h0000_0000, 1'b1), hs1); wait_idle();
        issue(mk(1'b0, 32'h8000_1020, 32'h0000_0000, 40, 32'hDEAD_BEEF, 1'b0), hs1); wait_idle();
        issue(mk(1'b0, 32'h8000_1024, 32'h0000_0000, T - 1, 32'hCAFE_F00D, 1'b0), hs1); wait_idle();
        issue(mk(1'b0, 32'h8000_1028, 32'h0000_0000, T, 32'hCAFE_F00D, 1'b0), hs1); wait_idle();

        // Back-to-back writes with req_valid held across the first response.
        issue(mk(1'b1, 32'h8000_1004, 32'h0000_00FF, 0, 32'h0, 1'b0), hs1);
        issue(mk(1'b1, 32'h8000_1008, 32'h0000_0055, 0, 32'h0, 1'b0), hs2);
        chk("b2b_handshake_gap", 64'(hs2 - hs1), 64'd3);
        wait_idle();

        // Reset while a read sits in ACCESS: transfer is dropped without a response.
        issue(mk(1'b0, 32'h8000_1030, 32'h0, 100, 32'h77, 1'b0), hs1);
        n = 0;
        while (!(bus_if.PSEL && bus_if.PENABLE) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_access", 64'(bus_if.PSEL && bus_if.PENABLE), 64'd1);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        plan_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        chk("midrst_psel", 64'(bus_if.PSEL), 64'd0);
        chk("midrst_penable", 64'(bus_if.PENABLE), 64'd0);
        chk("midrst_req_ready", 64'(bus_if.req_ready), 64'd0);
        chk("midrst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
        chk("midrst_paddr", 64'(bus_if.PADDR), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready_after_release", 64'(bus_if.req_ready), 64'd1);
        repeat (5) begin @(posedge clk); #1; end

        // Randomized traffic, mixing short waits, timeout-boundary waits and stuck completers.
        for (int i = 0; i < 80; i++) begin
            int r;
            p.wr    = 1'($urandom_range(0, 1));
            p.addr  = $urandom;
            p.wdata = $urandom;
            r = $urandom_range(0, 9);
            if (r < 6)      p.w = $urandom_range(0, 4);
            else if (r < 8) p.w = $urandom_range(T - 3, T + 1);
            else            p.w = $urandom_range(T + 2, T + 9);
            p.d = $urandom;
            p.e = 1'($urandom_range(0, 1));
            issue(p, hs1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_idle();
        chk("all_rsp_seen", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
